// File: rtl/note_tone_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_tone_gen_pkg
// Description : Shared definitions for the note tone generator: note code
//               width, per-note half-periods and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package note_tone_gen_pkg;

    localparam int NOTE_W  = 5;
    localparam int PHASE_W = 17;

    // Half-periods in clk cycles at 50 MHz; note_sel bit 4..0 selects C4..G4.
    localparam logic [PHASE_W-1:0] HALF_C4 = PHASE_W'(95556);
    localparam logic [PHASE_W-1:0] HALF_D4 = PHASE_W'(85131);
    localparam logic [PHASE_W-1:0] HALF_E4 = PHASE_W'(75843);
    localparam logic [PHASE_W-1:0] HALF_F4 = PHASE_W'(71586);
    localparam logic [PHASE_W-1:0] HALF_G4 = PHASE_W'(63776);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } tone_state_t;

    function automatic logic note_valid(input logic [NOTE_W-1:0] note);
        return $onehot(note);
    endfunction

    function automatic logic [PHASE_W-1:0] half_period(input logic [NOTE_W-1:0] note);
        logic [PHASE_W-1:0] half;
        case (note)
            5'b10000: half = HALF_C4;
            5'b01000: half = HALF_D4;
            5'b00100: half = HALF_E4;
            5'b00010: half = HALF_F4;
            5'b00001: half = HALF_G4;
            default:  half = HALF_C4;
        endcase
        return half;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_tone_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : note_tone_gen_if
// Description : Sample stream towards the codec FIFO (valid/ready handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface note_tone_gen_if #(
    parameter int AMP_W = 24
) ();

    logic [AMP_W-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface
`default_nettype wire

// File: rtl/note_tone_gen_sample_strobe.sv
`default_nettype none
// ============================================================================
// Module      : sample_strobe
// Description : Free-running divider producing a one-cycle tick every DIV clks.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_strobe #(
    parameter int DIV = 1042
) (
    input  wire logic clk,
    input  wire logic reset,
    output logic      tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/note_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : note_tone_gen
// Description : One-hot note code to ramped square-wave PCM sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
module note_tone_gen
    import note_tone_gen_pkg::*;
#(
    parameter int               SAMPLE_DIV = 1042,
    parameter int               AMP_W      = 24,
    parameter logic [AMP_W-1:0] AMP_MAX    = 24'h200000,
    parameter logic [AMP_W-1:0] RAMP_STEP  = 24'h004000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [NOTE_W-1:0] note_sel,
    note_tone_gen_if.master        smp,
    output logic                   busy,
    output logic                   overrun
);

    localparam int AMP_MAG_W = AMP_W - 1;
    localparam logic [AMP_MAG_W-1:0] c_amp_max = AMP_MAX[AMP_MAG_W-1:0];
    localparam logic [AMP_MAG_W-1:0] c_step    = RAMP_STEP[AMP_MAG_W-1:0];

    logic                 w_tick;
    logic [NOTE_W-1:0]    r_req;
    logic                 w_req_valid;
    logic [NOTE_W-1:0]    w_req;
    tone_state_t          r_state;
    tone_state_t          w_state_nxt;
    logic [NOTE_W-1:0]    r_cur_note;
    logic [NOTE_W-1:0]    w_cur_nxt;
    logic [AMP_MAG_W-1:0] r_amp;
    logic [AMP_MAG_W-1:0] w_amp_nxt;
    logic [AMP_W-1:0]     w_amp_up;
    logic [AMP_W-1:0]     w_amp_dn;
    logic                 w_amp_dn_zero;
    logic                 w_phase_zero;
    logic [PHASE_W-1:0]   r_hp_cnt;
    logic [PHASE_W-1:0]   w_half_last;
    logic                 r_pol;
    logic [AMP_W-1:0]     w_amp_ext;
    logic [AMP_W-1:0]     w_sample;
    logic [AMP_W-1:0]     r_sample;
    logic                 r_valid;
    logic                 r_overrun;

    sample_strobe #(
        .DIV (SAMPLE_DIV)
    ) u_strobe (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
        end else begin
            r_req <= note_sel;
        end
    end

    // Multi-hot and zero codes collapse to silence so every state sees one rule.
    assign w_req_valid = note_valid(r_req);
    assign w_req       = w_req_valid ? r_req : '0;

    // Saturating ramp arithmetic, one bit wider than the magnitude.
    assign w_amp_up      = {1'b0, r_amp} + {1'b0, c_step};
    assign w_amp_dn      = {1'b0, r_amp} - {1'b0, c_step};
    assign w_amp_dn_zero = w_amp_dn[AMP_W-1] || (w_amp_dn == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cur_note <= '0;
            r_amp      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_note <= w_cur_nxt;
            r_amp      <= w_amp_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur_note;
        w_amp_nxt    = r_amp;
        w_phase_zero = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        w_cur_nxt    = w_req;
                        w_phase_zero = 1'b1;
                        w_state_nxt  = ST_ATTACK;
                    end
                end
                ST_ATTACK: begin
                    if (w_req != r_cur_note) begin
                        w_state_nxt = ST_RELEASE;
                    end else if (w_amp_up >= {1'b0, c_amp_max}) begin
                        w_amp_nxt   = c_amp_max;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_amp_nxt = w_amp_up[AMP_MAG_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    if (w_req != r_cur_note) begin
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_req == r_cur_note) begin
                        w_state_nxt = ST_ATTACK;
                    end else if (w_amp_dn_zero) begin
                        w_amp_nxt = '0;
                        if (w_req_valid) begin
                            w_cur_nxt    = w_req;
                            w_phase_zero = 1'b1;
                            w_state_nxt  = ST_ATTACK;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_amp_nxt = w_amp_dn[AMP_MAG_W-1:0];
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_half_last = half_period(r_cur_note) - PHASE_W'(1);

    // Square-wave phase: runs only while a tone is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hp_cnt <= '0;
            r_pol    <= 1'b0;
        end else if (w_phase_zero || (r_state == ST_IDLE)) begin
            r_hp_cnt <= '0;
            r_pol    <= 1'b0;
        end else if (r_hp_cnt == w_half_last) begin
            r_hp_cnt <= '0;
            r_pol    <= ~r_pol;
        end else begin
            r_hp_cnt <= r_hp_cnt + PHASE_W'(1);
        end
    end

    assign w_amp_ext = {1'b0, r_amp};
    assign w_sample  = r_pol ? w_amp_ext : (~w_amp_ext + AMP_W'(1));

    // A tick always loads; overrun flags a load over an untransferred sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_tick) begin
            r_sample  <= w_sample;
            r_valid   <= 1'b1;
            r_overrun <= r_valid && !smp.sample_ready;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && smp.sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign smp.sample_data  = r_sample;
    assign smp.sample_valid = r_valid;
    assign busy             = (r_state != ST_IDLE);
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_note_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_tone_gen
// Description : Directed scoreboard bench for note_tone_gen (SAMPLE_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_tone_gen;

    localparam int SAMPLE_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] note_sel = 5'b00000;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_obs    = 0;
    logic [23:0] exp_q[$];

    note_tone_gen_if #(.AMP_W(24)) smp_if ();

    note_tone_gen #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .AMP_W      (24),
        .AMP_MAX    (24'h200000),
        .RAMP_STEP  (24'h080000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .note_sel (note_sel),
        .smp      (smp_if),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] neg(input logic [23:0] m);
        return ~m + 24'd1;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout, %0d samples still expected", tag, exp_q.size());
        exp_q.delete();
    endtask

    // Each transferred sample is compared against the oldest expectation.
    task automatic monitor();
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (smp_if.sample_valid && smp_if.sample_ready) begin
                n_obs++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sample", smp_if.sample_data, e);
                end
            end
        end
    endtask

    task automatic sync_tick(input string tag);
        for (int i = 0; i < 2 * SAMPLE_DIV + 4; i++) begin
            @(negedge clk);
            #1;
            if (smp_if.sample_valid) return;
        end
        bound_fail(tag);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        bound_fail(tag);
    endtask

    task automatic wait_obs(input string tag, input int n);
        int target;
        target = n_obs + n;
        for (int i = 0; i < 4 * n + 100; i++) begin
            @(negedge clk);
            #1;
            if (n_obs >= target) return;
        end
        bound_fail(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        smp_if.sample_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", smp_if.sample_data, 24'h000000);
        chk("rst_valid", 24'(smp_if.sample_valid), 24'd0);
        chk("rst_busy", 24'(busy), 24'd0);
        chk("rst_overrun", 24'(overrun), 24'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multi-hot request from IDLE is silence.
        sync_tick("sync_multihot");
        note_sel = 5'b11000;
        repeat (4) exp_q.push_back(24'h000000);
        wait_empty("multihot");
        chk("multihot_busy", 24'(busy), 24'd0);

        // C4 attack: IDLE tick, zero-amp ATTACK tick, then ramp to sustain.
        note_sel = 5'b10000;
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h000000);
        exp_q.push_back(neg(24'h080000));
        exp_q.push_back(neg(24'h100000));
        exp_q.push_back(neg(24'h180000));
        exp_q.push_back(neg(24'h200000));
        exp_q.push_back(neg(24'h200000));
        wait_empty("attack_c4");
        chk("sustain_busy", 24'(busy), 24'd1);

        // Release down to 0x100000, then same note resumes the attack.
        note_sel = 5'b00000;
        exp_q.push_back(neg(24'h200000));
        exp_q.push_back(neg(24'h200000));
        exp_q.push_back(neg(24'h180000));
        wait_empty("release_c4");
        note_sel = 5'b10000;
        exp_q.push_back(neg(24'h100000));
        exp_q.push_back(neg(24'h100000));
        exp_q.push_back(neg(24'h180000));
        exp_q.push_back(neg(24'h200000));
        wait_empty("reattack_c4");

        // Note change: full release on C4, then G4 attack with phase zeroed.
        note_sel = 5'b00001;
        exp_q.push_back(neg(24'h200000));
        exp_q.push_back(neg(24'h200000));
        exp_q.push_back(neg(24'h180000));
        exp_q.push_back(neg(24'h100000));
        exp_q.push_back(neg(24'h080000));
        exp_q.push_back(24'h000000);
        exp_q.push_back(neg(24'h080000));
        exp_q.push_back(neg(24'h100000));
        exp_q.push_back(neg(24'h180000));
        exp_q.push_back(neg(24'h200000));
        wait_empty("switch_g4");

        // G4 polarity flips 63776 clk after entry: tick 15944 still negative.
        wait_obs("g4_skip", 15937);
        exp_q.push_back(neg(24'h200000));
        exp_q.push_back(neg(24'h200000));
        exp_q.push_back(24'h200000);
        exp_q.push_back(24'h200000);
        wait_empty("g4_flip");

        // Backpressure across two ticks while releasing, then ready on a tick.
        note_sel = 5'b00000;
        repeat (5) @(posedge clk);
        #1;
        smp_if.sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_first_valid", 24'(smp_if.sample_valid), 24'd1);
        chk("bp_first_overrun", 24'(overrun), 24'd0);
        chk("bp_first_data", smp_if.sample_data, 24'h200000);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_second_overrun", 24'(overrun), 24'd1);
        chk("bp_second_data", smp_if.sample_data, 24'h180000);
        chk("bp_second_valid", 24'(smp_if.sample_valid), 24'd1);
        @(posedge clk);
        #1;
        chk("bp_overrun_pulse", 24'(overrun), 24'd0);
        chk("bp_data_hold", smp_if.sample_data, 24'h180000);
        repeat (2) @(posedge clk);
        #1;
        smp_if.sample_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_tick_valid", 24'(smp_if.sample_valid), 24'd1);
        chk("rdy_tick_overrun", 24'(overrun), 24'd0);
        chk("rdy_tick_data", smp_if.sample_data, 24'h100000);
        @(posedge clk);
        #1;
        chk("rdy_drop_valid", 24'(smp_if.sample_valid), 24'd0);

        // Asynchronous reset in SUSTAIN with a sample pending.
        sync_tick("sync_reset");
        note_sel = 5'b10000;
        wait_obs("reach_sustain", 8);
        chk("pre_rst_busy", 24'(busy), 24'd1);
        chk("pre_rst_valid", 24'(smp_if.sample_valid), 24'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_data", smp_if.sample_data, 24'h000000);
        chk("async_rst_valid", 24'(smp_if.sample_valid), 24'd0);
        chk("async_rst_busy", 24'(busy), 24'd0);
        chk("async_rst_overrun", 24'(overrun), 24'd0);
        note_sel = 5'b00000;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h000000);
        wait_empty("post_reset");
        chk("post_rst_busy", 24'(busy), 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
